tia_playfield_serializer: RTL
=============================

Name: tia_playfield_serializer

Overview:
Parametrised playfield pattern store and serializer, successor to the fixed 20-bit PF0/PF1/PF2 shift chain.
- CPU-side byte writes fill a PF_BITS-wide pattern register.
- Each visible line outputs the pattern twice, once per half, with PIX_PER_BIT clocks per playfield bit.
- The right half is either a repeat of the left or a mirror image of it.
- Sits between the TIA register decode and the colour/priority mux; output `pf` replaces the legacy playfield bit.

Parameters:
PF_BITS, 20, playfield bits per half-line (range 4..64)
PIX_PER_BIT, 4, clocks each bit is held (range 1..16)
NUM_BYTES, ceil(PF_BITS/8), derived; writable byte slots
IDX_W, max(1,clog2(NUM_BYTES)), derived; width of wr_idx

Ports:
clkp  in  1  pixel clock; all state changes on its rising edge
reset_bar  in  1  asynchronous active-low reset
line_start  in  1  single-cycle strobe: first visible pixel of the line
wr_en  in  1  pattern byte write strobe
wr_idx  in  IDX_W  byte slot to write
wr_data  in  8  byte data; bit j goes to pattern bit 8*wr_idx+j
reflect  in  1  1 = right half mirrored, 0 = right half repeated
pf  out  1  registered playfield pixel
pf_right  out  1  1 while the right half is being output
busy  out  1  1 while in LEFT or RIGHT
bit_idx  out  clog2(PF_BITS)  pattern bit currently driving pf

Behaviour:
- Clock and reset: one clock, clkp. reset_bar is asynchronous, active-low.
- Reset values: pattern=0, state=IDLE, pix_cnt=0, bit_cnt=0, pf=0, pf_right=0, busy=0, bit_idx=0.
- Pattern order: pattern bit 0 is displayed first in the left half.
- Writes:
  - On a wr_en edge, slot wr_idx is updated.
  - Bits at or beyond PF_BITS are dropped.
  - wr_idx >= NUM_BYTES is ignored.
  - Writes are accepted in every state.
- States: IDLE, LEFT, RIGHT.
- Bit load rule: at every edge where a new bit starts, pf <= pattern[bit] using the pre-edge pattern value. A write on the same edge is therefore visible from the next bit boundary, never mid-bit.
- IDLE:
  - line_start=1 -> LEFT, pix_cnt=0, bit_cnt=0, pf<=pattern[0].
  - pf stays high/low from the edge after line_start; there is no extra pipeline latency.
- LEFT:
  - pix_cnt increments each edge.
  - At pix_cnt==PIX_PER_BIT-1: pix_cnt<=0, bit_cnt++, load next bit.
  - After bit PF_BITS-1 completes -> RIGHT.
  - reflect is sampled on that edge: 1 gives bit_cnt<=PF_BITS-1 counting down; 0 gives bit_cnt<=0 counting up.
  - pf_right<=1 on that edge.
- RIGHT:
  - Counting as in LEFT.
  - A reflect change during RIGHT is ignored.
  - After the final bit (index 0 if mirrored, PF_BITS-1 if repeated) completes -> IDLE, pf<=0, pf_right<=0.
- Line length: total active length is exactly 2*PF_BITS*PIX_PER_BIT clocks.
- line_start in LEFT or RIGHT: restarts the line (same as from IDLE, pf_right<=0). The restart overrides the end-of-half transition on the same edge.
- Reset mid-line: immediate return to reset values. The pattern is cleared.
- PIX_PER_BIT=1: a new bit is loaded every edge; the pix_cnt compare is constantly true.
- busy = (state!=IDLE). bit_idx = bit_cnt.

Decomposition:
- Shared package `tia_pf_pkg`:
  - state enum {IDLE, LEFT, RIGHT};
  - function clog2;
  - constants TIA_PF_BITS=20 and TIA_PIX_PER_BIT=4;
  - helper function mapping legacy PF0/PF1/PF2 bit order to the linear pattern index, used by the TIA wrapper.
- One sub-module, `tia_pf_bit_timer`: pix_cnt/bit_cnt up/down counter. Outputs bit_done and half_done strobes; takes a direction input.
- Pattern storage and FSM stay in the top level.

Test Plan:
All scenarios use defaults PF_BITS=20, PIX_PER_BIT=4.
1. Reset while the pattern is nonzero and state is LEFT:
   - assert reset_bar=0 mid-clock -> pf=0, busy=0 immediately;
   - after release, one line with no writes -> pf=0 for all 160 clocks.
2. Repeat mode:
   - writes 0x01, 0x00, 0x08 to slots 0/1/2, giving pattern bits 0 and 19 set; reflect=0; line_start at edge E0;
   - required: pf=1 for clocks E0..E0+3, E0+76..79, E0+80..83, E0+156..159; pf=0 otherwise;
   - busy drops at edge E0+160.
3. Reflect mode, same pattern with reflect=1:
   - pf=1 at E0..3, E0+76..79, E0+80..83, E0+156..159;
   - bit_idx=19 at E0+80 and 0 at E0+156.
4. Mid-line write:
   - pattern=0, line_start at E0; wr_en slot 0 data 0x04 at edge E0+8 (bit 2 boundary);
   - required: pf=0 at E0+8..11; pf=0 at bit 2 of the left half (old value used);
   - pf=1 for E0+88..91 in the right half (repeat mode).
5. line_start re-asserted at E0+50:
   - state restarts; pf_right stays 0;
   - busy holds through E0+209 and drops at E0+210.
6. Parameter sweep:
   - PF_BITS=8, PIX_PER_BIT=1, pattern 0xA5, reflect=1;
   - pf sequence 1,0,1,0,0,1,0,1 then 1,0,1,0,0,1,0,1 (mirror of a palindrome);
   - a write to wr_idx=1 is ignored.

Source files
------------

// File: rtl/tia_pf_pkg.sv
// rtl/tia_pf_pkg.sv - shared types, constants and helpers for the playfield serializer
package tia_pf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } pf_state_e;

  localparam int TIA_PF_BITS     = 20;
  localparam int TIA_PIX_PER_BIT = 4;

  // Ceiling log2; clog2(1) is 0, callers clamp to 1 where a width is needed.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Legacy PF0/PF1/PF2 bit to linear pattern index (display order).
  // PF0 uses bits 4..7 (bit 4 first), PF1 is shown MSB first, PF2 LSB first.
  // Returns -1 for PF0 bits 0..3, which were never displayed.
  function automatic int legacy_pf_index(input logic [1:0] reg_sel, input logic [2:0] bit_pos);
    int idx;
    idx = -1;
    case (reg_sel)
      2'd0: if (bit_pos >= 3'd4) idx = int'(bit_pos) - 4;
      2'd1: idx = 4 + (7 - int'(bit_pos));
      2'd2: idx = 12 + int'(bit_pos);
      default: idx = -1;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/tia_pf_bit_timer.sv
// rtl/tia_pf_bit_timer.sv - pixel/bit counter with up/down bit index and half strobes
module tia_pf_bit_timer
  import tia_pf_pkg::*;
#(
  parameter int PF_BITS     = TIA_PF_BITS,
  parameter int PIX_PER_BIT = TIA_PIX_PER_BIT,
  parameter int BIT_W       = clog2(PF_BITS),
  parameter int PIX_W       = (clog2(PIX_PER_BIT) > 0) ? clog2(PIX_PER_BIT) : 1
) (
  input  logic             clkp,
  input  logic             reset_bar,
  input  logic             run_i,        // a half-line is in progress
  input  logic             start_i,      // begin a line at bit 0, counting up
  input  logic             turn_i,       // begin the right half
  input  logic             turn_down_i,  // direction for the right half (1 = down)
  output logic             bit_done_o,   // last pixel of the current bit
  output logic             half_done_o,  // last pixel of the last bit of this half
  output logic [BIT_W-1:0] bit_cnt_o,
  output logic [BIT_W-1:0] next_bit_o
);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PF_BITS - 1);

  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             down_q, down_d;

  // With PIX_PER_BIT=1 PIX_LAST is 0 and pix_cnt never leaves 0, so every edge ends a bit.
  assign bit_done_o  = run_i && (pix_cnt_q == PIX_LAST);
  assign half_done_o = bit_done_o && (bit_cnt_q == (down_q ? '0 : BIT_LAST));
  assign next_bit_o  = down_q ? (bit_cnt_q - BIT_W'(1)) : (bit_cnt_q + BIT_W'(1));
  assign bit_cnt_o   = bit_cnt_q;

  // Next counter values: start beats turn beats end-of-half beats normal counting.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    bit_cnt_d = bit_cnt_q;
    down_d    = down_q;
    if (start_i) begin
      pix_cnt_d = '0;
      bit_cnt_d = '0;
      down_d    = 1'b0;
    end else if (turn_i) begin
      pix_cnt_d = '0;
      bit_cnt_d = turn_down_i ? BIT_LAST : '0;
      down_d    = turn_down_i;
    end else if (half_done_o) begin
      pix_cnt_d = '0;
      bit_cnt_d = '0;
      down_d    = 1'b0;
    end else if (bit_done_o) begin
      pix_cnt_d = '0;
      bit_cnt_d = next_bit_o;
    end else if (run_i) begin
      pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      pix_cnt_q <= '0;
      bit_cnt_q <= '0;
      down_q    <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      down_q    <= down_d;
    end
  end

endmodule

// File: rtl/tia_playfield_serializer.sv
// rtl/tia_playfield_serializer.sv - playfield pattern store and two-half line serializer
module tia_playfield_serializer
  import tia_pf_pkg::*;
#(
  parameter int PF_BITS     = TIA_PF_BITS,
  parameter int PIX_PER_BIT = TIA_PIX_PER_BIT,
  parameter int NUM_BYTES   = (PF_BITS + 7) / 8,
  parameter int IDX_W       = (clog2(NUM_BYTES) > 0) ? clog2(NUM_BYTES) : 1,
  parameter int BIT_W       = clog2(PF_BITS)
) (
  input  logic             clkp,
  input  logic             reset_bar,
  input  logic             line_start,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             reflect,
  output logic             pf,
  output logic             pf_right,
  output logic             busy,
  output logic [BIT_W-1:0] bit_idx
);

  pf_state_e          state_q, state_d;
  logic [PF_BITS-1:0] pattern_q, pattern_d;
  logic               pf_q, pf_d;
  logic               pf_right_q, pf_right_d;
  logic               start, turn;
  logic               bit_done, half_done;
  logic [BIT_W-1:0]   bit_cnt, next_bit;

  tia_pf_bit_timer #(
    .PF_BITS    (PF_BITS),
    .PIX_PER_BIT(PIX_PER_BIT),
    .BIT_W      (BIT_W)
  ) u_timer (
    .clkp       (clkp),
    .reset_bar  (reset_bar),
    .run_i      (state_q != IDLE),
    .start_i    (start),
    .turn_i     (turn),
    .turn_down_i(reflect),
    .bit_done_o (bit_done),
    .half_done_o(half_done),
    .bit_cnt_o  (bit_cnt),
    .next_bit_o (next_bit)
  );

  // Byte write into the pattern; only bits that exist for this slot are touched,
  // so out-of-range slots and bits past PF_BITS fall out naturally.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en) begin
      for (int b = 0; b < PF_BITS; b++) begin
        if ((b / 8) == int'(wr_idx)) pattern_d[b] = wr_data[b % 8];
      end
    end
  end

  // Line FSM; every new bit samples the pre-edge pattern so writes never land mid-bit.
  always_comb begin
    state_d    = state_q;
    pf_d       = pf_q;
    pf_right_d = pf_right_q;
    start      = 1'b0;
    turn       = 1'b0;
    if (line_start) begin
      state_d    = LEFT;
      start      = 1'b1;
      pf_d       = pattern_q[0];
      pf_right_d = 1'b0;
    end else begin
      case (state_q)
        LEFT: begin
          if (half_done) begin
            state_d    = RIGHT;
            turn       = 1'b1;
            pf_right_d = 1'b1;
            pf_d       = reflect ? pattern_q[PF_BITS-1] : pattern_q[0];
          end else if (bit_done) begin
            pf_d = pattern_q[next_bit];
          end
        end
        RIGHT: begin
          if (half_done) begin
            state_d    = IDLE;
            pf_d       = 1'b0;
            pf_right_d = 1'b0;
          end else if (bit_done) begin
            pf_d = pattern_q[next_bit];
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, pattern and output registers.
  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      pf_q       <= 1'b0;
      pf_right_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pf_q       <= pf_d;
      pf_right_q <= pf_right_d;
    end
  end

  assign pf       = pf_q;
  assign pf_right = pf_right_q;
  assign busy     = (state_q != IDLE);
  assign bit_idx  = bit_cnt;

endmodule
